huffman_merge_ctrl: RTL and testbench

//  Sequencer that builds a Huffman tree by repeatedly driving the descendSort datapath.

---
 rtl/huffman_merge_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_huffman_merge_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_merge_ctrl.sv
// huffman_merge_ctrl
//   Sequencer that builds a Huffman tree with an external descending sorter.
//   It loads DEPTH symbol probabilities and then repeats the same steps: sort the
//   working set, merge the two smallest active entries into a new internal node,
//   and emit a merge record. After DEPTH-1 merges one node remains and done pulses.
//   Inactive slots hold the all-ones filler value, so they always sort to the top
//   and the active entries sit at the low end (indices DEPTH-n..DEPTH-1).

module huffman_merge_ctrl #(
  parameter int DEPTH = 8,
  parameter int PW    = 8,
  parameter int IDW   = $clog2(2*DEPTH)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DEPTH*PW-1:0]  in_prob,
  output logic                 sort_valid,
  input  logic                 sort_ready,
  output logic [DEPTH*PW-1:0]  sort_prob,
  output logic [DEPTH*IDW-1:0] sort_id,
  input  logic                 sort_done,
  input  logic [DEPTH*PW-1:0]  sorted_prob,
  input  logic [DEPTH*IDW-1:0] sorted_id,
  output logic                 mrg_valid,
  input  logic                 mrg_ready,
  output logic [IDW-1:0]       mrg_left,
  output logic [IDW-1:0]       mrg_right,
  output logic [IDW-1:0]       mrg_node,
  output logic [PW-1:0]        mrg_prob,
  output logic                 busy,
  output logic                 done
);

  // Active-entry counter must be able to hold the value DEPTH itself.
  localparam int NW = $clog2(DEPTH + 1);

  // All-ones marks an empty slot; real probabilities top out one below it.
  localparam logic [PW-1:0] FILL    = {PW{1'b1}};
  localparam logic [PW-1:0] SAT_MAX = {{(PW-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SORT_REQ  = 3'd1,
    S_SORT_WAIT = 3'd2,
    S_MERGE     = 3'd3,
    S_EMIT      = 3'd4,
    S_FIN       = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  // Working set presented to the sorter.
  logic [PW-1:0]  prob [DEPTH];
  logic [IDW-1:0] id   [DEPTH];
  logic [NW-1:0]  n_act;
  logic [IDW-1:0] next_id;

  logic          load_en;
  logic          capture_en;
  logic          merge_en;
  logic [PW-1:0] merge_sum;

  // Incoming values equal to the filler would be mistaken for empty slots.
  function automatic logic [PW-1:0] clamp_load(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == FILL) begin
      r = SAT_MAX;
    end else begin
      r = p;
    end
    return r;
  endfunction

  // Full-width add, then saturate so the result never collides with the filler.
  function automatic logic [PW-1:0] sat_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW:0]   s;
    logic [PW-1:0] r;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, SAT_MAX}) begin
      r = SAT_MAX;
    end else begin
      r = s[PW-1:0];
    end
    return r;
  endfunction

  assign load_en    = (state == S_IDLE) && in_valid;
  assign capture_en = (state == S_SORT_WAIT) && sort_done;
  assign merge_en   = (state == S_MERGE);
  assign merge_sum  = sat_add(prob[DEPTH-2], prob[DEPTH-1]);

  // State register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic for the load / sort / merge / emit loop.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_next = S_SORT_REQ;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_SORT_REQ: begin
        if (sort_ready) begin
          state_next = S_SORT_WAIT;
        end else begin
          state_next = S_SORT_REQ;
        end
      end
      S_SORT_WAIT: begin
        if (sort_done) begin
          state_next = S_MERGE;
        end else begin
          state_next = S_SORT_WAIT;
        end
      end
      S_MERGE: begin
        state_next = S_EMIT;
      end
      S_EMIT: begin
        if (mrg_ready) begin
          if (n_act > NW'(1)) begin
            state_next = S_SORT_REQ;
          end else begin
            state_next = S_FIN;
          end
        end else begin
          state_next = S_EMIT;
        end
      end
      S_FIN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Handshake and status flags, registered from the next state so they line up with it.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      in_ready   <= 1'b1;
      sort_valid <= 1'b0;
      mrg_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      in_ready   <= (state_next == S_IDLE);
      sort_valid <= (state_next == S_SORT_REQ);
      mrg_valid  <= (state_next == S_EMIT);
      busy       <= (state_next != S_IDLE);
      done       <= (state_next == S_FIN);
    end
  end

  // Working set: load the leaves, take sorter results, fold the two smallest together.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        prob[i] <= '0;
        id[i]   <= '0;
      end
      n_act   <= '0;
      next_id <= '0;
    end else if (load_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        prob[i] <= clamp_load(in_prob[i*PW +: PW]);
        id[i]   <= IDW'(i);
      end
      n_act   <= NW'(DEPTH);
      next_id <= IDW'(DEPTH);
    end else if (capture_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        prob[i] <= sorted_prob[i*PW +: PW];
        id[i]   <= sorted_id[i*IDW +: IDW];
      end
    end else if (merge_en) begin
      prob[DEPTH-2] <= merge_sum;
      id[DEPTH-2]   <= next_id;
      prob[DEPTH-1] <= FILL;
      id[DEPTH-1]   <= '0;
      n_act         <= n_act - NW'(1);
      next_id       <= next_id + IDW'(1);
    end else begin
      n_act   <= n_act;
      next_id <= next_id;
    end
  end

  // Merge record, captured during the merge cycle and held while it is offered.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      mrg_left  <= '0;
      mrg_right <= '0;
      mrg_node  <= '0;
      mrg_prob  <= '0;
    end else if (merge_en) begin
      mrg_left  <= id[DEPTH-2];
      mrg_right <= id[DEPTH-1];
      mrg_node  <= next_id;
      mrg_prob  <= merge_sum;
    end else begin
      mrg_left  <= mrg_left;
      mrg_right <= mrg_right;
      mrg_node  <= mrg_node;
      mrg_prob  <= mrg_prob;
    end
  end

  // Flatten the working set onto the sorter request buses.
  always_comb begin
    sort_prob = '0;
    sort_id   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sort_prob[i*PW +: PW]  = prob[i];
      sort_id[i*IDW +: IDW]  = id[i];
    end
  end

endmodule

// File: tb/tb_huffman_merge_ctrl.sv
// tb_huffman_merge_ctrl
//   Directed bench with a stable descending-sort model standing in for descendSort.
//   Stimulus pushes hand-computed merge records into a queue; a monitor pops and
//   compares on every accepted record. A protocol watcher checks that stalled
//   requests and records stay stable.

module tb_huffman_merge_ctrl;

  localparam int DEPTH    = 8;
  localparam int PW       = 8;
  localparam int IDW      = 4;
  localparam int SORT_LAT = 3;

  logic                 clock;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [DEPTH*PW-1:0]  in_prob;
  logic                 sort_valid;
  logic                 sort_ready;
  logic [DEPTH*PW-1:0]  sort_prob;
  logic [DEPTH*IDW-1:0] sort_id;
  logic                 sort_done;
  logic [DEPTH*PW-1:0]  sorted_prob;
  logic [DEPTH*IDW-1:0] sorted_id;
  logic                 mrg_valid;
  logic                 mrg_ready;
  logic [IDW-1:0]       mrg_left;
  logic [IDW-1:0]       mrg_right;
  logic [IDW-1:0]       mrg_node;
  logic [PW-1:0]        mrg_prob;
  logic                 busy;
  logic                 done;

  huffman_merge_ctrl #(.DEPTH(DEPTH), .PW(PW), .IDW(IDW)) dut (
    .clock(clock), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_prob(in_prob),
    .sort_valid(sort_valid), .sort_ready(sort_ready),
    .sort_prob(sort_prob), .sort_id(sort_id),
    .sort_done(sort_done), .sorted_prob(sorted_prob), .sorted_id(sorted_id),
    .mrg_valid(mrg_valid), .mrg_ready(mrg_ready),
    .mrg_left(mrg_left), .mrg_right(mrg_right), .mrg_node(mrg_node), .mrg_prob(mrg_prob),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [IDW-1:0] left;
    logic [IDW-1:0] right;
    logic [IDW-1:0] node;
    logic [PW-1:0]  prob;
    bit             chk_ids;
  } rec_t;

  rec_t exp_q[$];
  int errors       = 0;
  int checks       = 0;
  int acc_cnt      = 0;
  int done_cnt     = 0;
  int sort_req_cnt = 0;

  // Hand-computed records (stable sort on ties).
  int t1_p [8] = '{10, 5, 2, 25, 6, 4, 3, 44};
  int t1_l [7] = '{6, 8, 4, 0, 11, 12, 13};
  int t1_r [7] = '{2, 5, 1, 9, 10, 3, 7};
  int t1_pr[7] = '{5, 9, 11, 19, 30, 55, 99};
  int t6_p [8] = '{255, 1, 2, 3, 4, 5, 6, 7};
  int t6_l [7] = '{2, 3, 5, 6, 10, 12, 0};
  int t6_r [7] = '{1, 8, 4, 9, 7, 11, 13};
  int t6_pr[7] = '{3, 6, 9, 12, 16, 28, 254};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DEPTH*PW-1:0] pack_set(input int sel);
    logic [DEPTH*PW-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      case (sel)
        1:       v[i*PW +: PW] = 8'(t1_p[i]);
        3:       v[i*PW +: PW] = 8'd200;
        6:       v[i*PW +: PW] = 8'(t6_p[i]);
        default: v[i*PW +: PW] = 8'd0;
      endcase
    end
    return v;
  endfunction

  task automatic push_run(input int sel);
    rec_t e;
    for (int k = 0; k < DEPTH - 1; k++) begin
      e.node    = 4'(8 + k);
      e.chk_ids = (sel != 3);
      case (sel)
        1: begin e.left = 4'(t1_l[k]); e.right = 4'(t1_r[k]); e.prob = 8'(t1_pr[k]); end
        6: begin e.left = 4'(t6_l[k]); e.right = 4'(t6_r[k]); e.prob = 8'(t6_pr[k]); end
        default: begin e.left = 4'd0; e.right = 4'd0; e.prob = 8'd254; end
      endcase
      exp_q.push_back(e);
    end
  endtask

  // Wait for the controller to be idle, then offer one set for a single cycle.
  task automatic start_run(input string nm, input logic [DEPTH*PW-1:0] p);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clock); #1;
      if (in_ready) got = 1'b1;
    end
    chk({nm, "_in_ready_wait"}, 64'(got), 64'd1);
    in_prob  = p;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int  start;
    bit  got;
    start = done_cnt;
    got   = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(posedge clock); #1;
      if (done_cnt > start) got = 1'b1;
    end
    chk({nm, "_done_seen"}, 64'(got), 64'd1);
    if (got) begin
      chk({nm, "_in_ready_after"}, 64'(in_ready), 64'd1);
      chk({nm, "_records_left"}, 64'(exp_q.size()), 64'd0);
    end
  endtask

  // Descending-sort model: stable insertion sort, result after SORT_LAT cycles.
  initial begin
    logic [PW-1:0]  p [DEPTH];
    logic [IDW-1:0] d [DEPTH];
    logic [PW-1:0]  kp;
    logic [IDW-1:0] kd;
    int  cd;
    int  j;
    bit  pend;
    sort_done   = 1'b0;
    sorted_prob = '0;
    sorted_id   = '0;
    pend        = 1'b0;
    cd          = 0;
    forever begin
      @(negedge clock);
      sort_done = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else if (pend) begin
        cd--;
        if (cd == 0) begin
          sort_done = 1'b1;
          pend      = 1'b0;
        end
      end else if (sort_valid && sort_ready) begin
        for (int i = 0; i < DEPTH; i++) begin
          p[i] = sort_prob[i*PW +: PW];
          d[i] = sort_id[i*IDW +: IDW];
        end
        for (int i = 1; i < DEPTH; i++) begin
          kp = p[i];
          kd = d[i];
          j  = i - 1;
          while (j >= 0 && p[j] < kp) begin
            p[j+1] = p[j];
            d[j+1] = d[j];
            j--;
          end
          p[j+1] = kp;
          d[j+1] = kd;
        end
        for (int i = 0; i < DEPTH; i++) begin
          sorted_prob[i*PW +: PW]  = p[i];
          sorted_id[i*IDW +: IDW]  = d[i];
        end
        pend = 1'b1;
        cd   = SORT_LAT;
        sort_req_cnt++;
      end
    end
  end

  // Monitor: compare every accepted merge record against the queue, count done pulses.
  initial begin
    rec_t e;
    forever begin
      @(negedge clock);
      if (!rst) begin
        if (done) done_cnt++;
        if (mrg_valid && mrg_ready) begin
          acc_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_record left=%0d right=%0d node=%0d prob=%0d",
                     mrg_left, mrg_right, mrg_node, mrg_prob);
          end else begin
            e = exp_q.pop_front();
            if (mrg_node !== e.node || mrg_prob !== e.prob ||
                (e.chk_ids && (mrg_left !== e.left || mrg_right !== e.right))) begin
              errors++;
              $display("FAIL record actual l=%0d r=%0d n=%0d p=%0d expected l=%0d r=%0d n=%0d p=%0d (ids checked=%0d)",
                       mrg_left, mrg_right, mrg_node, mrg_prob,
                       e.left, e.right, e.node, e.prob, e.chk_ids);
            end
          end
        end
      end
    end
  end

  // Protocol watcher: a stalled request or record must stay put with no other activity.
  initial begin
    bit ms;
    bit ss;
    logic [IDW*3+PW-1:0]  prev_rec;
    logic [DEPTH*PW-1:0]  prev_sp;
    logic [DEPTH*IDW-1:0] prev_si;
    ms = 1'b0;
    ss = 1'b0;
    forever begin
      @(negedge clock);
      if (rst) begin
        ms = 1'b0;
        ss = 1'b0;
      end else begin
        if (ms) begin
          checks++;
          if (!mrg_valid || sort_valid || {mrg_left, mrg_right, mrg_node, mrg_prob} !== prev_rec) begin
            errors++;
            $display("FAIL mrg_hold actual valid=%0d sort_valid=%0d rec=0x%0h expected valid=1 sort_valid=0 rec=0x%0h",
                     mrg_valid, sort_valid, {mrg_left, mrg_right, mrg_node, mrg_prob}, prev_rec);
          end
        end
        if (ss) begin
          checks++;
          if (!sort_valid || !busy || mrg_valid || sort_prob !== prev_sp || sort_id !== prev_si) begin
            errors++;
            $display("FAIL sort_hold actual valid=%0d busy=%0d mrg_valid=%0d prob=0x%0h id=0x%0h expected valid=1 busy=1 mrg_valid=0 prob=0x%0h id=0x%0h",
                     sort_valid, busy, mrg_valid, sort_prob, sort_id, prev_sp, prev_si);
          end
        end
        ms       = mrg_valid && !mrg_ready;
        ss       = sort_valid && !sort_ready;
        prev_rec = {mrg_left, mrg_right, mrg_node, mrg_prob};
        prev_sp  = sort_prob;
        prev_si  = sort_id;
      end
    end
  end

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_in_ready"},   64'(in_ready),   64'd1);
    chk({nm, "_sort_valid"}, 64'(sort_valid), 64'd0);
    chk({nm, "_mrg_valid"},  64'(mrg_valid),  64'd0);
    chk({nm, "_busy"},       64'(busy),       64'd0);
    chk({nm, "_done"},       64'(done),       64'd0);
    chk({nm, "_mrg_node"},   64'(mrg_node),   64'd0);
    chk({nm, "_mrg_prob"},   64'(mrg_prob),   64'd0);
  endtask

  // Main stimulus sequence.
  initial begin
    int  base;
    int  dn;
    bit  got;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_prob    = '0;
    sort_ready = 1'b1;
    mrg_ready  = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_outputs("reset");
    @(posedge clock); #1;
    rst = 1'b0;

    // T1: plain run.
    push_run(1);
    start_run("t1", pack_set(1));
    wait_done("t1");

    // T2: downstream stalls the third record for 20 cycles.
    push_run(1);
    base = acc_cnt;
    start_run("t2", pack_set(1));
    got = 1'b0;
    for (int k = 0; k < 500 && !got; k++) begin
      @(posedge clock); #1;
      if (acc_cnt >= base + 2) got = 1'b1;
    end
    chk("t2_two_records", 64'(got), 64'd1);
    mrg_ready = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 500 && !got; k++) begin
      @(posedge clock); #1;
      if (mrg_valid) got = 1'b1;
    end
    chk("t2_rec3_valid", 64'(got), 64'd1);
    base = sort_req_cnt;
    repeat (20) @(posedge clock);
    #1;
    chk("t2_no_sort_during_stall", 64'(sort_req_cnt), 64'(base));
    mrg_ready = 1'b1;
    wait_done("t2");

    // T3: saturating sums.
    push_run(3);
    start_run("t3", pack_set(3));
    wait_done("t3");

    // T4: sorter refuses the request for 15 cycles.
    push_run(1);
    sort_ready = 1'b0;
    start_run("t4", pack_set(1));
    chk("t4_sort_valid", 64'(sort_valid), 64'd1);
    repeat (15) @(posedge clock);
    #1;
    chk("t4_no_record_yet", 64'(exp_q.size()), 64'd7);
    sort_ready = 1'b1;
    wait_done("t4");

    // T6: filler value clamped on load, in_valid during a run ignored.
    push_run(6);
    start_run("t6", pack_set(6));
    chk("t6_first_sort_valid", 64'(sort_valid), 64'd1);
    chk("t6_first_sort_prob",  64'(sort_prob),  64'h0706050403020_1FE);
    chk("t6_first_sort_id",    64'(sort_id),    64'h76543210);
    in_prob  = pack_set(3);
    in_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("t6_in_ready_busy", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    wait_done("t6");

    // T5: reset while the fourth sort is outstanding, then a fresh run.
    push_run(1);
    base = sort_req_cnt;
    start_run("t5", pack_set(1));
    got = 1'b0;
    for (int k = 0; k < 500 && !got; k++) begin
      @(posedge clock); #1;
      if (sort_req_cnt >= base + 4) got = 1'b1;
    end
    chk("t5_fourth_sort", 64'(got), 64'd1);
    dn  = done_cnt;
    rst = 1'b1;
    @(negedge clock);
    chk_reset_outputs("t5_abort");
    chk("t5_records_before_abort", 64'(exp_q.size()), 64'd4);
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("t5_no_done", 64'(done_cnt), 64'(dn));
    push_run(1);
    start_run("t5b", pack_set(1));
    wait_done("t5b");

    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
